mem_arbiter: RTL
================

# mem_arbiter

Shares the single-port, synchronous-read word memory between the core's instruction-fetch port and its load/store port. Each cycle it grants at most one requester, drives the memory, and routes the read data back to the granted port one cycle later. It sits between the multi-cycle core state machine and the `MEM` array. It lets fetch and load/store proceed without the core serialising them by hand.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width (256 words).
- `STARVE_MAX`, 4: consecutive cycles the fetch port may be denied while requesting before it is forced through.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `i_req` in 1: fetch request.
- `i_addr` in ADDR_W: fetch word address.
- `i_gnt` out 1: fetch request accepted this cycle.
- `i_rvalid` out 1: `i_rdata` is valid.
- `i_rdata` out 32: fetched instruction.
- `d_req` in 1: load/store request.
- `d_we` in 1: request is a store.
- `d_wmask` in 4: byte enables for a store.
- `d_addr` in ADDR_W: load/store word address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: load/store accepted this cycle.
- `d_rvalid` out 1: load data valid, or store completed.
- `d_rdata` out 32: load data.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 4: byte write enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_en`.

## Operation
- Requester rule: a requester holds `req`, address, `we`, `wmask` and `wdata` stable until it sees `gnt` high. It may drop `req` or issue a new request in the cycle after `gnt`.
- Arbitration is combinational from `i_req`, `d_req` and the registered arbitration state.
  - Default policy: fixed priority, data port over fetch port.
  - Starvation guard: `starve_cnt` increments each cycle `i_req` is high and `i_gnt` is low. It clears when `i_gnt` is high or `i_req` is low. While `starve_cnt == STARVE_MAX`, the fetch port wins.
- Grant outputs:
  - At most one of `i_gnt` and `d_gnt` is high in any cycle.
  - `mem_en` equals `i_gnt | d_gnt`.
  - `mem_addr` and `mem_wdata` come from the granted port. They are 0 when neither port is granted.
  - `mem_we` equals `d_wmask` when `d_gnt & d_we`, otherwise 0.
- Response tag register `resp`, with values NONE, I and D:
  - Loads `I` on `i_gnt`, `D` on `d_gnt`, otherwise `NONE`.
  - `i_rvalid` is `resp==I`; `d_rvalid` is `resp==D`.
  - Both `rdata` outputs pass `mem_rdata` through combinationally. Their value is meaningful only while the matching `rvalid` is high.
- Throughput: one grant per cycle, fully pipelined. A new grant may coincide with the previous grant's response.
- Store on `d_we`: `d_rvalid` still pulses the next cycle as a completion strobe. `d_rdata` is don't-care in that cycle.
- Address width: addresses are `ADDR_W` bits with no range check. The core drops the byte-offset bits before driving the address.

## Timing
- Reset: while `resetn` is low, all grants are gated low and `mem_en`/`mem_we` are 0. On the next edge, `resp` loads NONE, `starve_cnt` loads 0 and the round-robin pointer loads fetch-next.
- All outputs are 0 in the first cycle after reset, except `rdata`, which follows `mem_rdata`.
- Reset mid-operation: a grant in the cycle before reset is asserted produces no `rvalid`. The response is discarded.
- Latency: `gnt` is in cycle N; `rvalid` is exactly cycle N+1; there are no wait states.
- Simultaneous `i_req` and `d_req`: the data port wins unless the starvation guard or round-robin policy dictates otherwise. The loser holds and sees `gnt` in a later cycle.
- `starve_cnt` saturates at `STARVE_MAX`. It never wraps.

## Configuration
- `MEM_ARBITER_RR_EN` defined: the policy is round-robin.
  - A 1-bit pointer records the next favoured port and flips to the other port after each grant.
  - With both requesting continuously, grants alternate I, D, I, D, ...
  - The starvation guard is compiled out, because it is redundant.
- Undefined: fixed data priority plus the starvation guard, as described in Operation.

## Structure
- Package `mem_arbiter_pkg` holds:
  - response tag encoding: NONE=2'd0, I=2'd1, D=2'd2;
  - port index constants `PORT_I=0`, `PORT_D=1`;
  - the default `STARVE_MAX`.
- One sub-module, `mem_arbiter_starve_cnt`, is natural: a saturating counter with inc/clear inputs and an `at_max` output.
  - It is instantiated only when `MEM_ARBITER_RR_EN` is undefined.

## Test plan
- Fetch only: `i_req=1`, `i_addr=5`, with `MEM[5]=0x00100093` → `i_gnt` in the same cycle, `i_rvalid=1` and `i_rdata=0x00100093` the next cycle.
- Store then load: `d_we=1`, `d_wmask=4'b0011`, `d_addr=3`, `d_wdata=0xAABBCCDD` over `MEM[3]=0` → `mem_we=0011` and `d_rvalid` next cycle. A following load of address 3 returns `0x0000CCDD`.
- Contention, fixed policy: `i_req` and `d_req` held high with `d_req` re-issued every cycle → grants are D×4 then I, repeating. `i_gnt` never waits more than `STARVE_MAX` cycles.
- Contention with `MEM_ARBITER_RR_EN`: both ports held requesting → grants alternate I, D, I, D. `rvalid` follows each grant by one cycle on the matching port.
- Reset mid-operation: `resetn` low in the cycle after `d_gnt` → `d_rvalid` stays 0, and all outputs are 0 the cycle after reset.
- Idle: no requests → `mem_en=0`, `mem_we=0`, both `rvalid` 0 on every cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Purpose : shared constants for the fetch/load-store memory arbiter.
// Latency : n/a (constants only).
// Backpressure: n/a. Build option MEM_ARBITER_RR_EN selects round-robin in mem_arbiter.
package mem_arbiter_pkg;

    // Response tag carried one cycle behind the grant.
    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_I    = 2'd1;
    localparam logic [1:0] RESP_D    = 2'd2;

    // Port indices, also used as the round-robin pointer encoding.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Cycles a requesting fetch port may lose before it is forced through.
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose : bundle of the fetch port, load/store port and memory port of mem_arbiter.
// Latency : n/a; gnt is combinational with req, rvalid/rdata follow gnt by one cycle.
// Backpressure: req/addr/we/wmask/wdata held by the requester until gnt.
// Modports: slave = arbiter side, master = core + memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8
);
    // fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    // load/store port
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_wmask;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    // memory port
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_wmask, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_wmask, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// Purpose : saturating count of consecutive cycles the fetch port was denied.
// Latency : o_at_max is registered state, one cycle behind the inc that reaches MAX.
// Backpressure: none. Ports: clk, resetn (sync, active-low), i_inc, i_clr, o_at_max.
module mem_arbiter_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] r_cnt;

    // Clear wins over increment; the count holds once it reaches MAX.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == CW'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : grants one of fetch / load-store per cycle onto a single-port sync-read memory.
// Latency : gnt same cycle as req; rvalid/rdata exactly one cycle after gnt, fully pipelined.
// Backpressure: loser keeps req held and is granted later; fixed data priority with a
//   fetch starvation guard, or round-robin when MEM_ARBITER_RR_EN is defined.
// Ports: clk, resetn (sync, active-low), bus (mem_arbiter_if.slave: fetch, load/store, memory).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus
);

    logic              w_i_win;   // fetch wins when both ports request
    logic              w_i_gnt;
    logic              w_d_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        r_resp;

`ifdef MEM_ARBITER_RR_EN
    // Pointer names the port favoured next; it moves away from whoever was just granted.
    logic r_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr <= PORT_I;
        end else if (w_i_gnt) begin
            r_ptr <= PORT_D;
        end else if (w_d_gnt) begin
            r_ptr <= PORT_I;
        end
    end

    assign w_i_win = (r_ptr == PORT_I);
`else
    logic w_at_max;

    mem_arbiter_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .i_inc    (bus.i_req & ~w_i_gnt),
        .i_clr    (~bus.i_req | w_i_gnt),
        .o_at_max (w_at_max)
    );

    assign w_i_win = w_at_max;
`endif

    // Grants are gated by resetn so nothing reaches memory while reset is held.
    assign w_i_gnt = resetn & bus.i_req & (~bus.d_req | w_i_win);
    assign w_d_gnt = resetn & bus.d_req & ~w_i_gnt;

    assign w_addr = w_d_gnt ? bus.d_addr :
                    w_i_gnt ? bus.i_addr : '0;

    assign bus.i_gnt     = w_i_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.mem_en    = w_i_gnt | w_d_gnt;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_d_gnt ? bus.d_wdata : 32'd0;
    assign bus.mem_we    = (w_d_gnt & bus.d_we) ? bus.d_wmask : 4'd0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_resp <= RESP_NONE;
        end else if (w_i_gnt) begin
            r_resp <= RESP_I;
        end else if (w_d_gnt) begin
            r_resp <= RESP_D;
        end else begin
            r_resp <= RESP_NONE;
        end
    end

    // resetn gating drops the response of a grant issued just before reset.
    assign bus.i_rvalid = resetn & (r_resp == RESP_I);
    assign bus.d_rvalid = resetn & (r_resp == RESP_D);
    assign bus.i_rdata  = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;

endmodule
